// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment digit scanner.
package ssd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIG_W      = 2;

    localparam logic AN_OFF = 1'b1;
    localparam logic AN_ON  = 1'b0;

    typedef logic [DIG_W-1:0] digit_t;

    // Nibble of a 16-bit value belonging to digit position d.
    function automatic logic [3:0] nibble_sel(input logic [15:0] v, input digit_t d);
        return v[{d, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/ssd_prescaler.sv
// Per-slot tick counter: flags the last tick of a slot and the leading guard window.
module ssd_prescaler #(
    parameter int DIV   = 100000,
    parameter int BLANK = 1000
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic tick_last_o,
    output logic in_guard_o
);

    localparam int            TW       = $clog2(DIV);
    localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);

    logic [TW-1:0] tick_q;
    logic [TW-1:0] tick_d;

    // Next tick: wrap to zero at the end of the slot.
    always_comb begin
        tick_d = tick_q;
        if (tick_q == TICK_MAX) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + TW'(1);
        end
    end

    // Tick register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick_last_o = (tick_q == TICK_MAX);

    // With no guard interval the comparison would be constant-false.
    generate
        if (BLANK == 0) begin : g_no_guard
            assign in_guard_o = 1'b0;
        end else begin : g_guard
            localparam logic [TW-1:0] BLANK_T = TW'(BLANK);
            assign in_guard_o = (tick_q < BLANK_T);
        end
    endgenerate

endmodule

// File: rtl/ssd_scan.sv
// Four-digit multiplexed hex display scanner with frame-synchronous double buffering.
module ssd_scan
    import ssd_pkg::*;
#(
    parameter int DIV   = 100000,
    parameter int BLANK = 1000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] VALUE,
    input  logic        LOAD,
    input  logic [3:0]  DIGIT_EN,
    output logic [3:0]  NIBBLE,
    output logic        SSD_AN0,
    output logic        SSD_AN1,
    output logic        SSD_AN2,
    output logic        SSD_AN3,
    output logic        PENDING,
    output logic        FRAME
);

    logic        tick_last_s;
    logic        in_guard_s;
    logic        boundary_s;

    digit_t      digit_q;
    digit_t      digit_d;
    logic [15:0] shadow_q;
    logic [15:0] shadow_d;
    logic [15:0] pbuf_q;
    logic [15:0] pbuf_d;
    logic        pend_q;
    logic        pend_d;
    logic [3:0]  den_q;
    logic [NUM_DIGITS-1:0] an_s;

    ssd_prescaler #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_prescaler (
        .clk_i       (CLK),
        .reset_i     (RESET),
        .tick_last_o (tick_last_s),
        .in_guard_o  (in_guard_s)
    );

    assign boundary_s = tick_last_s && (digit_q == digit_t'(NUM_DIGITS - 1));

    // Digit advance and buffer update; a load in the boundary cycle bypasses the pending buffer.
    always_comb begin
        digit_d  = digit_q;
        shadow_d = shadow_q;
        pbuf_d   = pbuf_q;
        pend_d   = pend_q;
        if (tick_last_s) begin
            digit_d = digit_q + 2'd1;
        end else begin
            digit_d = digit_q;
        end
        if (boundary_s) begin
            pend_d = 1'b0;
            if (LOAD) begin
                shadow_d = VALUE;
            end else if (pend_q) begin
                shadow_d = pbuf_q;
            end else begin
                shadow_d = shadow_q;
            end
        end else if (LOAD) begin
            pbuf_d = VALUE;
            pend_d = 1'b1;
        end else begin
            pbuf_d = pbuf_q;
            pend_d = pend_q;
        end
    end

    // State registers; digit enables are registered so no input reaches an output combinationally.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            digit_q  <= 2'd0;
            shadow_q <= 16'h0000;
            pbuf_q   <= 16'h0000;
            pend_q   <= 1'b0;
            den_q    <= 4'h0;
        end else begin
            digit_q  <= digit_d;
            shadow_q <= shadow_d;
            pbuf_q   <= pbuf_d;
            pend_q   <= pend_d;
            den_q    <= DIGIT_EN;
        end
    end

    // Anode decode: only the current digit, only after the guard window, only if enabled.
    always_comb begin
        an_s = {NUM_DIGITS{AN_OFF}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!in_guard_s && den_q[i] && (digit_q == digit_t'(i))) begin
                an_s[i] = AN_ON;
            end else begin
                an_s[i] = AN_OFF;
            end
        end
    end

    assign NIBBLE  = nibble_sel(shadow_q, digit_q);
    assign SSD_AN0 = an_s[0];
    assign SSD_AN1 = an_s[1];
    assign SSD_AN2 = an_s[2];
    assign SSD_AN3 = an_s[3];
    assign PENDING = pend_q;
    assign FRAME   = boundary_s;

endmodule

// File: tb/tb_ssd_scan.sv
// Bench for ssd_scan: cycle-count based reference model plus directed and random stimulus.
module tb_ssd_scan;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FLEN  = 4 * DIV;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] VALUE;
    logic        LOAD;
    logic [3:0]  DIGIT_EN;
    logic [3:0]  NIBBLE;
    logic        SSD_AN0, SSD_AN1, SSD_AN2, SSD_AN3;
    logic        PENDING;
    logic        FRAME;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    int          m_n;
    logic [15:0] m_shadow;
    logic [15:0] m_pbuf;
    logic        m_pflag;
    logic [3:0]  m_den;

    logic [3:0] an_s;
    assign an_s = {SSD_AN3, SSD_AN2, SSD_AN1, SSD_AN0};

    ssd_scan #(.DIV(DIV), .BLANK(BLANK)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .VALUE    (VALUE),
        .LOAD     (LOAD),
        .DIGIT_EN (DIGIT_EN),
        .NIBBLE   (NIBBLE),
        .SSD_AN0  (SSD_AN0),
        .SSD_AN1  (SSD_AN1),
        .SSD_AN2  (SSD_AN2),
        .SSD_AN3  (SSD_AN3),
        .PENDING  (PENDING),
        .FRAME    (FRAME)
    );

    always #5 CLK = ~CLK;

    // Reference model: position follows from cycles since reset; buffers follow the load rules.
    always @(posedge CLK) begin
        if (RESET) begin
            m_n = 0; m_shadow = 16'h0; m_pbuf = 16'h0; m_pflag = 1'b0; m_den = 4'h0;
        end else begin
            if (m_n % FLEN == FLEN - 1) begin
                if (LOAD) m_shadow = VALUE;
                else if (m_pflag) m_shadow = m_pbuf;
                m_pflag = 1'b0;
            end else if (LOAD) begin
                m_pbuf  = VALUE;
                m_pflag = 1'b1;
            end
            m_n++;
            m_den = DIGIT_EN;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge CLK) begin
        int         tk, dg;
        logic [3:0] e_an, e_nib;
        logic       e_fr;
        if (chk_en) begin
            tk    = m_n % DIV;
            dg    = (m_n / DIV) % 4;
            e_fr  = (tk == DIV - 1) && (dg == 3);
            e_nib = 4'((m_shadow >> (4 * dg)) & 16'h000F);
            e_an  = 4'hF;
            if (tk >= BLANK && m_den[dg]) e_an[dg] = 1'b0;
            vectors += 5;
            if (NIBBLE !== e_nib) begin
                miscompares++;
                $display("FAIL nibble n=%0d: got %h expected %h", m_n, NIBBLE, e_nib);
            end
            if (an_s !== e_an) begin
                miscompares++;
                $display("FAIL anodes n=%0d: got %b expected %b", m_n, an_s, e_an);
            end
            if (PENDING !== m_pflag) begin
                miscompares++;
                $display("FAIL pending n=%0d: got %b expected %b", m_n, PENDING, m_pflag);
            end
            if (FRAME !== e_fr) begin
                miscompares++;
                $display("FAIL frame n=%0d: got %b expected %b", m_n, FRAME, e_fr);
            end
            if ($countones(~an_s) > 1) begin
                miscompares++;
                $display("FAIL onehot n=%0d: got %b expected at most one low", m_n, an_s);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_frame(output int cnt);
        cnt = 0;
        do begin
            @(negedge CLK);
            cnt++;
        end while (FRAME !== 1'b1 && cnt < 100);
        if (FRAME !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_timeout: got no FRAME expected one within 100 cycles");
        end
    endtask

    task automatic load(input logic [15:0] v);
        VALUE = v;
        LOAD  = 1'b1;
        @(negedge CLK);
        LOAD  = 1'b0;
    endtask

    initial begin
        int c;
        RESET = 1'b1; LOAD = 1'b0; VALUE = 16'h0; DIGIT_EN = 4'h0;
        repeat (2) @(negedge CLK);
        chk_en = 1'b1;
        chk("rst_an", {28'h0, an_s}, 32'hF);
        chk("rst_nibble", {28'h0, NIBBLE}, 32'h0);
        chk("rst_pending", {31'h0, PENDING}, 32'h0);
        chk("rst_frame", {31'h0, FRAME}, 32'h0);
        RESET = 1'b0;
        @(negedge CLK);

        // Basic load, frame-synchronous apply, slot layout and period.
        DIGIT_EN = 4'hF;
        load(16'h1234);
        chk("t1_pending_set", {31'h0, PENDING}, 32'h1);
        wait_frame(c);
        chk("t1_old_nibble", {28'h0, NIBBLE}, 32'h0);
        @(negedge CLK);
        chk("t1_pending_clr", {31'h0, PENDING}, 32'h0);
        chk("t1_slot0_nib", {28'h0, NIBBLE}, 32'h4);
        chk("t1_guard_an", {28'h0, an_s}, 32'hF);
        repeat (2) @(negedge CLK);
        chk("t1_slot0_an", {28'h0, an_s}, 32'hE);
        wait_frame(c);
        wait_frame(c);
        chk("t1_period", c, 32'd32);
        chk("t1_slot3_nib", {28'h0, NIBBLE}, 32'h1);
        chk("t1_slot3_an", {28'h0, an_s}, 32'h7);

        // Last load before the boundary wins.
        repeat (5) @(negedge CLK);
        load(16'hAAAA);
        repeat (3) @(negedge CLK);
        load(16'h5555);
        chk("t3_pending", {31'h0, PENDING}, 32'h1);
        wait_frame(c);
        chk("t3_pending_at_frame", {31'h0, PENDING}, 32'h1);
        @(negedge CLK);
        chk("t3_pending_clr", {31'h0, PENDING}, 32'h0);
        chk("t3_nibble", {28'h0, NIBBLE}, 32'h5);

        // Load exactly in the boundary cycle goes straight to the display.
        wait_frame(c);
        load(16'hBEEF);
        chk("t4_pending", {31'h0, PENDING}, 32'h0);
        chk("t4_dig0", {28'h0, NIBBLE}, 32'hF);
        repeat (8) @(negedge CLK);
        chk("t4_dig1", {28'h0, NIBBLE}, 32'hE);

        // Digit enables suppress upper anodes.
        DIGIT_EN = 4'b0011;
        load(16'h00C4);
        wait_frame(c);
        wait_frame(c);
        chk("t5_an3_off", {28'h0, an_s}, 32'hF);
        repeat (3) @(negedge CLK);
        chk("t5_an0", {28'h0, an_s}, 32'hE);
        chk("t5_nib0", {28'h0, NIBBLE}, 32'h4);

        // Randomized traffic including occasional resets.
        for (int i = 0; i < 600; i++) begin
            LOAD     = ($urandom_range(0, 7) == 0);
            VALUE    = 16'($urandom);
            DIGIT_EN = 4'($urandom);
            RESET    = ($urandom_range(0, 249) == 0);
            @(negedge CLK);
        end
        RESET = 1'b0; LOAD = 1'b0; DIGIT_EN = 4'hF;

        // Reset mid-frame discards the pending value and restarts at digit 0.
        wait_frame(c);
        @(negedge CLK);
        load(16'h9876);
        repeat (16) @(negedge CLK);
        chk("t6_pending_before", {31'h0, PENDING}, 32'h1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("t6_an", {28'h0, an_s}, 32'hF);
        chk("t6_nibble", {28'h0, NIBBLE}, 32'h0);
        chk("t6_pending", {31'h0, PENDING}, 32'h0);
        wait_frame(c);
        chk("t6_restart", c, 32'd31);
        @(negedge CLK);
        chk("t6_discarded", {28'h0, NIBBLE}, 32'h0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ssd_scan.md
Name: ssd_scan

Overview:
Upstream stage of seg7. Time-multiplexes a 16-bit hex value across the 4-digit seven-segment display. Per digit slot it drives one active-low anode and presents that digit's nibble to seg7 (NIBBLE[3]→Z, [2]→Y, [1]→X, [0]→W). New values are double-buffered and applied only at a frame boundary, so the display never tears. Each slot starts with an all-anodes-off guard interval to suppress ghosting.

Parameters:
DIV, 100000, clock cycles per digit slot; legal range ≥2.
BLANK, 1000, guard cycles at the start of each slot with all anodes off; legal range 0 ≤ BLANK < DIV.

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
VALUE  in  16  hex value; digit i = VALUE[4i+3:4i]; digit 0 on AN0
LOAD  in  1  one-cycle strobe; captures VALUE into the pending buffer
DIGIT_EN  in  4  per-digit enable (e.g. leading-zero blanking); sampled live
NIBBLE  out  4  nibble for the current slot, to seg7
SSD_AN0..SSD_AN3  out  1 each  anodes, active-low
PENDING  out  1  high while a loaded value waits for the frame boundary
FRAME  out  1  one-cycle pulse on each 3→0 digit wrap

Behaviour:
- Reset (RESET=1 at a clock edge): tick=0, digit=0, shadow=0, pending buffer=0, PENDING=0, FRAME=0, NIBBLE=0, all SSD_AN*=1. Reset overrides LOAD. It applies mid-frame without completing the slot.
- tick counter: counts 0..DIV-1. At DIV-1 it wraps to 0 and digit advances 0→1→2→3→0.
- Frame boundary: the cycle with tick=DIV-1 and digit=3.
  - FRAME=1 for exactly that cycle.
  - At its edge, shadow←pending buffer if PENDING=1, and PENDING clears.
- LOAD:
  - Not at a boundary: pending←VALUE, PENDING=1 from the next cycle.
  - LOAD while PENDING=1: overwrites the pending buffer (last load wins).
  - LOAD in the boundary cycle: VALUE goes straight to shadow and PENDING ends 0.
- Anodes: SSD_AN[digit]=0 iff tick ≥ BLANK and DIGIT_EN[digit]=1. All other anodes are 1. At most one anode is low in any cycle.
- NIBBLE = shadow[4·digit+3 : 4·digit]. It stays valid through the guard interval so seg7 settles before the anode turns on.
- All outputs are pure functions of registered state. There is no combinational path from any input to any output, so DIGIT_EN changes take effect one cycle later.
- BLANK=0: no guard interval; an enabled anode is low for the whole slot.
- Frame period = 4·DIV cycles. Shadow changes only at a frame boundary edge, or at reset.

Decomposition:
- Package ssd_pkg:
  - NUM_DIGITS=4.
  - AN_OFF=1'b1 and AN_ON=1'b0.
  - Digit-index width of 2.
- Sub-module ssd_prescaler(DIV):
  - Contains the tick counter.
  - Outputs: tick_last (tick=DIV-1) and in_guard (tick<BLANK).
- ssd_scan holds the digit counter, the shadow and pending buffers, and the output decode. It is instantiated alongside seg7 in the top-level display wrapper.

Test Plan (DIV=8, BLANK=2):
1. Reset, then LOAD VALUE=16'h1234, DIGIT_EN=4'hF → PENDING=1 until the first FRAME. In the next frame, slot 0 gives NIBBLE=4 and slot 3 gives NIBBLE=1. AN_k is low only for ticks 2..7 of slot k. FRAME pulses every 32 cycles.
2. Guard check: at tick 0..1 of every slot all anodes=1. Across 3 frames, never more than one anode is low.
3. LOAD 16'hAAAA mid-frame, then LOAD 16'h5555 before the boundary → the next frame shows 5 on all digits, never A. PENDING falls in the cycle after FRAME.
4. LOAD 16'hBEEF exactly in the FRAME cycle → the next frame shows F,E,E,B on digits 0..3 and PENDING stays 0.
5. DIGIT_EN=4'b0011 with value 16'h00C4 → AN2 and AN3 stay 1 throughout. AN0 and AN1 scan normally, with NIBBLE=4 then C.
6. Assert RESET during slot 2 with PENDING=1 → next cycle all anodes=1, NIBBLE=0, PENDING=0. Scanning restarts at digit 0 and the pending value is discarded.
